// File: rtl/pifo_pkg.sv
// Shared types and helpers for the PIFO and its STFQ rank stage.
package pifo_pkg;

    typedef logic [31:0] rank_t;

    localparam int SHIFT_W = 3;

    // Unsigned add that clamps at all-ones instead of wrapping.
    function automatic rank_t sat_add32(input rank_t a, input rank_t b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? '1 : sum[31:0];
    endfunction

    // True when exactly one bit is set; callers zero-extend their flow vector.
    function automatic logic onehot_ok(input logic [31:0] v);
        return (v != '0) && ((v & (v - 32'd1)) == '0);
    endfunction

endpackage

// File: rtl/stfq_flow_table.sv
// Per-flow STFQ state: finish time, weight shift and PIFO occupancy.
// Read is a one-hot mux; writes are one-hot update strobes.
module stfq_flow_table
    import pifo_pkg::*;
#(
    parameter int FLOWS     = 10,
    parameter int BANK_SIZE = 50,
    parameter int OCC_W     = $clog2(BANK_SIZE + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [FLOWS-1:0]   rd_flow,
    output rank_t              rd_finish,
    output logic [SHIFT_W-1:0] rd_shift,
    output logic [OCC_W-1:0]   rd_occ,
    input  logic               wr_en,
    input  logic [FLOWS-1:0]   wr_flow,
    input  rank_t              wr_finish,
    input  logic               deq_en,
    input  logic [FLOWS-1:0]   deq_flow,
    input  logic               cfg_we,
    input  logic [FLOWS-1:0]   cfg_flow,
    input  logic [SHIFT_W-1:0] cfg_shift
);

    rank_t              finish [FLOWS];
    logic [SHIFT_W-1:0] shift  [FLOWS];
    logic [OCC_W-1:0]   occ    [FLOWS];

    logic [FLOWS-1:0] inc;
    logic [FLOWS-1:0] dec;

    // One-hot read mux plus per-flow increment/decrement strobes.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves a latch.
        rd_finish = '0;
        rd_shift  = '0;
        rd_occ    = '0;
        inc       = '0;
        dec       = '0;
        for (int f = 0; f < FLOWS; f++) begin
            if (rd_flow[f]) begin
                rd_finish = rd_finish | finish[f];
                rd_shift  = rd_shift  | shift[f];
                rd_occ    = rd_occ    | occ[f];
            end
            inc[f] = wr_en && wr_flow[f];
            // A dequeue against an empty count is ignored.
            dec[f] = deq_en && deq_flow[f] && (occ[f] != '0);
        end
    end

    // Finish/shift/occupancy update; accept and dequeue on one flow cancel.
    always_ff @(posedge clk) begin
        // NOTE: this state is architecturally visible after reset, so the whole table clears rather than being left as uninitialised RAM.
        if (!rst) begin
            for (int f = 0; f < FLOWS; f++) begin
                finish[f] <= '0;
                shift[f]  <= '0;
                occ[f]    <= '0;
            end
        end else begin
            for (int f = 0; f < FLOWS; f++) begin
                // NOTE: non-blocking so every read in this edge sees pre-edge state.
                if (inc[f]) finish[f] <= wr_finish;
                if (cfg_we && cfg_flow[f]) shift[f] <= cfg_shift;
                if (inc[f] && !dec[f]) begin
                    occ[f] <= occ[f] + OCC_W'(1);
                end else if (dec[f] && !inc[f]) begin
                    occ[f] <= occ[f] - OCC_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/stfq_rank.sv
// STFQ rank stage: computes start-time ranks from per-flow finish times and
// a virtual clock driven by PIFO dequeues, and registers the PIFO push.
module stfq_rank
    import pifo_pkg::*;
#(
    parameter int FLOWS     = 10,
    parameter int BANK_SIZE = 50
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [FLOWS-1:0]   in_flow,
    input  logic [31:0]        in_length,
    input  logic [31:0]        in_value,
    input  logic               cfg_we,
    input  logic [FLOWS-1:0]   cfg_flow,
    input  logic [SHIFT_W-1:0] cfg_shift,
    input  logic               deq_valid,
    input  logic [FLOWS-1:0]   deq_flow,
    input  logic [31:0]        deq_rank,
    output logic               push,
    output logic [31:0]        push_rank,
    output logic [31:0]        push_value,
    output logic [FLOWS-1:0]   push_flow,
    output logic [31:0]        drop_count
);

    localparam int OCC_W = $clog2(BANK_SIZE + 1);

    rank_t              vt;
    rank_t              rd_finish;
    logic [SHIFT_W-1:0] rd_shift;
    logic [OCC_W-1:0]   rd_occ;

    logic  flow_ok;
    logic  accept;
    logic  push_en;
    logic  drop_en;
    logic  deq_en;
    rank_t start;
    rank_t next_finish;

    assign flow_ok  = onehot_ok(32'(in_flow));
    // Only a well-formed flow can be full; malformed packets are always taken and dropped.
    assign in_ready = !(flow_ok && (rd_occ == OCC_W'(BANK_SIZE)));
    assign accept   = in_valid && in_ready;
    assign push_en  = accept && flow_ok;
    assign drop_en  = accept && !flow_ok;
    assign deq_en   = deq_valid && onehot_ok(32'(deq_flow));

    // Rank uses pre-edge vt, so a same-cycle dequeue only affects later packets.
    assign start       = (vt > rd_finish) ? vt : rd_finish;
    assign next_finish = sat_add32(start, in_length >> rd_shift);

    stfq_flow_table #(
        .FLOWS     (FLOWS),
        .BANK_SIZE (BANK_SIZE),
        .OCC_W     (OCC_W)
    ) u_table (
        .clk       (clk),
        .rst       (rst),
        .rd_flow   (in_flow),
        .rd_finish (rd_finish),
        .rd_shift  (rd_shift),
        .rd_occ    (rd_occ),
        .wr_en     (push_en),
        .wr_flow   (in_flow),
        .wr_finish (next_finish),
        .deq_en    (deq_en),
        .deq_flow  (deq_flow),
        .cfg_we    (cfg_we),
        .cfg_flow  (cfg_flow),
        .cfg_shift (cfg_shift)
    );

    // Virtual clock: monotonic max of dequeued ranks.
    always_ff @(posedge clk) begin
        if (!rst) begin
            vt <= '0;
        end else if (deq_valid && (deq_rank > vt)) begin
            vt <= deq_rank;
        end
    end

    // Saturating count of packets dropped for a malformed flow vector.
    always_ff @(posedge clk) begin
        if (!rst) begin
            drop_count <= '0;
        end else if (drop_en && (drop_count != '1)) begin
            drop_count <= drop_count + 32'd1;
        end
    end

    // Push register: one-cycle pulse per well-formed accept, payload held between pushes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            push       <= 1'b0;
            push_rank  <= '0;
            push_value <= '0;
            push_flow  <= '0;
        end else begin
            push <= push_en;
            if (push_en) begin
                push_rank  <= start;
                push_value <= in_value;
                push_flow  <= in_flow;
            end
        end
    end

endmodule
